// File: rtl/clock_enable_gen_pkg.sv
// clk_pkg: state encoding and default divider settings shared by the clock enable generator
package clk_pkg;
  typedef enum logic [1:0] {ST_WAIT_LOCK = 2'd0, ST_HOLD = 2'd1, ST_RUN = 2'd2} state_t;
  localparam int DIV_PIX_DEF = 8;
  localparam int DIV_CPU_DEF = 16;
  localparam int HOLD_DEF = 1024;
endpackage

// File: rtl/clock_enable_gen_sync2.sv
// sync2: two-flop synchroniser for a single asynchronous level, reset to 0
module sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [1:0] s_q, s_d;
  always_comb s_d = {s_q[0], d};
  always_ff @(posedge clock or negedge reset)
    if (!reset) s_q <= '0;
    else s_q <= s_d;
  assign q = s_q[1];
endmodule

// File: rtl/clock_enable_gen.sv
// clock_enable_gen: lock-qualified core reset release and pixel/CPU phase enables from the system clock
module clock_enable_gen
  import clk_pkg::*;
#(
  parameter int DIV_PIX = DIV_PIX_DEF,
  parameter int DIV_CPU = DIV_CPU_DEF,
  parameter int HOLD = HOLD_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic locked,
  input  logic cpuStop,
  output logic rstOut,
  output logic ce7p,
  output logic ce7n,
  output logic ceCpuP,
  output logic ceCpuN
);
  localparam int HW = $clog2(HOLD);
  localparam int PW = $clog2(DIV_CPU);
  logic lock_s, run, pix_p, pix_n;
  state_t state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [4:0] out_q, out_d;
  sync2 u_sync (.clock(clock), .reset(reset), .d(locked), .q(lock_s));
  always_comb begin
    state_d = state_q;
    hold_d = '0;
    case (state_q)
      ST_WAIT_LOCK: if (lock_s) state_d = ST_HOLD;
      ST_HOLD:
        if (!lock_s) state_d = ST_WAIT_LOCK;
        else if (hold_q == HW'(HOLD - 1)) state_d = ST_RUN;
        else hold_d = hold_q + 1'b1;
      ST_RUN: if (!lock_s) state_d = ST_WAIT_LOCK;
      default: state_d = ST_WAIT_LOCK;
    endcase
  end
  // lock loss gates the enables immediately so no pulse escapes on the way out of RUN
  always_comb begin
    run = (state_q == ST_RUN) && lock_s;
    phase_d = !run ? '0 : (phase_q == PW'(DIV_CPU - 1)) ? '0 : phase_q + 1'b1;
    pix_p = (phase_q == '0) || (phase_q == PW'(DIV_PIX));
    pix_n = (phase_q == PW'(DIV_PIX / 2)) || (phase_q == PW'(DIV_PIX + DIV_PIX / 2));
    out_d = run ? {1'b1, pix_p, pix_n, (phase_q == '0) && !cpuStop,
                   (phase_q == PW'(DIV_CPU / 2)) && !cpuStop} : '0;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= ST_WAIT_LOCK;
      hold_q <= '0;
      phase_q <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      phase_q <= phase_d;
      out_q <= out_d;
    end
  assign {rstOut, ce7p, ce7n, ceCpuP, ceCpuN} = out_q;
endmodule

// File: tb/tb_clock_enable_gen.sv
// tb_clock_enable_gen: scoreboarded per-cycle check of reset release, enable patterns, stop and lock loss
module tb_clock_enable_gen;
  localparam int HOLD = 1024;
  logic clock = 0, reset = 0, locked = 1, cpuStop = 0;
  logic rstOut, ce7p, ce7n, ceCpuP, ceCpuN;
  logic [4:0] act;
  logic [4:0] exp_q[$];
  int n_cmp = 0, n_bad = 0;
  int c7p = 0, c7n = 0, ccp = 0, ccn = 0;
  int s7p, s7n, scp, scn;

  clock_enable_gen dut (
    .clock(clock), .reset(reset), .locked(locked), .cpuStop(cpuStop),
    .rstOut(rstOut), .ce7p(ce7p), .ce7n(ce7n), .ceCpuP(ceCpuP), .ceCpuN(ceCpuN)
  );

  always #5 clock = ~clock;
  assign act = {rstOut, ce7p, ce7n, ceCpuP, ceCpuN};

  task automatic chk(input string nm, input logic [4:0] a, input logic [4:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b want %b (rst,7p,7n,cP,cN)", nm, $time, a, e);
    end
  endtask

  task automatic chk_i(input string nm, input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d want %0d", nm, $time, a, e);
    end
  endtask

  // expected outputs for run cycle k, where k=0 is the first cycle rstOut is high
  function automatic logic [4:0] ev(input int k, input logic st);
    return {1'b1, k % 8 == 0, k % 8 == 4, (k % 16 == 0) && !st, (k % 16 == 8) && !st};
  endfunction

  task automatic step(input logic r, input logic lk, input logic st, input logic [4:0] e);
    @(negedge clock);
    reset = r;
    locked = lk;
    cpuStop = st;
    exp_q.push_back(e);
    @(posedge clock);
  endtask

  always @(posedge clock) begin
    #1;
    c7p += int'(ce7p);
    c7n += int'(ce7n);
    ccp += int'(ceCpuP);
    ccn += int'(ceCpuN);
    if (exp_q.size() != 0) chk("cycle", act, exp_q.pop_front());
  end

  initial begin
    repeat (10) step(0, 1, 0, 5'b0);
    for (int i = 0; i < HOLD + 3; i++) step(1, 1, 0, 5'b0);
    #2;
    s7p = c7p; s7n = c7n; scp = ccp; scn = ccn;
    for (int k = 0; k < 160; k++) step(1, 1, 0, ev(k, 0));
    #2;
    chk_i("ce7p_count", c7p - s7p, 20);
    chk_i("ce7n_count", c7n - s7n, 20);
    chk_i("ceCpuP_count", ccp - scp, 10);
    chk_i("ceCpuN_count", ccn - scn, 10);
    for (int k = 160; k < 213; k++) step(1, 1, k < 192, ev(k, k < 192));
    step(1, 0, 0, ev(213, 0));
    step(1, 0, 0, ev(214, 0));
    repeat (4) step(1, 0, 0, 5'b0);
    for (int i = 1; i <= 1528; i++) step(1, i != 501, 0, 5'b0);
    for (int k = 0; k <= 40; k++) step(1, 1, 0, ev(k, 0));
    #2;
    chk("pre_async", act, 5'b11001);
    reset = 0;
    #1;
    chk("async_reset", act, 5'b0);
    repeat (3) step(0, 1, 0, 5'b0);
    #2;
    chk_i("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
